mem_fill_arbiter: RTL and testbench

- Owns the single-ported, multi-cycle main memory. Shares it between the I-cache (block fills), the D-cache (block fills) and D-cache write-through stores.
- Converts each granted fill into WORDS_PER_BLOCK pipelined single-word reads. Counts the returning words and steers them to the granted cache with a word index.
- Sits between both cache instances and the memory model. Replaces the ad-hoc I/D mem-fetch steering in the cpu top level.

---
 rtl/mem_fill_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the single-ported main memory between I-cache fills, D-cache fills
// and D-cache write-through stores; each fill is issued as pipelined word reads.
module mem_fill_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int FAIR            = 1,
    localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_fill_valid,
    output logic              i_done,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_grant,
    output logic              d_fill_valid,
    output logic              d_done,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_wr_ack,
    output logic [DATA_W-1:0] fill_data,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic              busy
);
    localparam int CNT_W = IDX_W + 1;
    // Words are two address units apart, so a block spans 2*WORDS_PER_BLOCK addresses.
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << (IDX_W + 1);

    typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic              last_was_d_q, last_was_d_d;
    logic [ADDR_W-1:0] issue_off;
    logic              fill_is_d;

    assign issue_off = ADDR_W'(issue_cnt_q) << 1;
    assign fill_is_d = (state_q == FILL_D);
    assign fill_data = mem_rdata;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            last_was_d_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            last_was_d_q <= last_was_d_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        last_was_d_d = last_was_d_q;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        d_wr_ack     = 1'b0;
        fill_idx     = '0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                // Stores first; fairness lets I in right after a D fill.
                if (d_wr_req) begin
                    state_d = WRITE;
                end else if ((FAIR != 0) && last_was_d_q && i_req) begin
                    state_d = FILL_I;
                    base_d  = i_addr & BASE_MASK;
                end else if (d_req) begin
                    state_d = FILL_D;
                    base_d  = d_addr & BASE_MASK;
                end else if (i_req) begin
                    state_d = FILL_I;
                    base_d  = i_addr & BASE_MASK;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                d_wr_ack  = 1'b1;
                state_d   = IDLE;
            end
            FILL_I, FILL_D: begin
                i_grant = !fill_is_d;
                d_grant = fill_is_d;
                if (issue_cnt_q < CNT_W'(WORDS_PER_BLOCK)) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_q + issue_off;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (mem_data_valid) begin
                    i_fill_valid = !fill_is_d;
                    d_fill_valid = fill_is_d;
                    fill_idx     = ret_cnt_q;
                    ret_cnt_d    = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == IDX_W'(WORDS_PER_BLOCK - 1)) begin
                        i_done       = !fill_is_d;
                        d_done       = fill_is_d;
                        state_d      = IDLE;
                        last_was_d_d = fill_is_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: fixed-latency memory model, transaction-timeline
// reference model, vector table, directed corner sequences and random cache agents.
module tb_mem_fill_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int WPB = 8;
    localparam int LAT = 4;
    localparam int IW  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_req, d_req, d_wr_req;
    logic [AW-1:0] i_addr, d_addr, d_wr_addr;
    logic [DW-1:0] d_wr_data;
    logic          i_grant, i_fill_valid, i_done, d_grant, d_fill_valid, d_done, d_wr_ack;
    logic [DW-1:0] fill_data, mem_wdata, mem_rdata;
    logic [IW-1:0] fill_idx;
    logic          mem_en, mem_wr, mem_data_valid, busy;
    logic [AW-1:0] mem_addr;
    logic          force_v;

    mem_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB), .MEM_LATENCY(LAT), .FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_fill_valid(i_fill_valid), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_grant(d_grant), .d_fill_valid(d_fill_valid), .d_done(d_done),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid), .busy(busy));

    // Second instance without fairness
    logic          i_req2, d_req2;
    logic          i_grant2, i_fill_valid2, i_done2, d_grant2, d_fill_valid2, d_done2, d_wr_ack2;
    logic [DW-1:0] fill_data2, mem_wdata2, mem_rdata2;
    logic [IW-1:0] fill_idx2;
    logic          mem_en2, mem_wr2, mem_data_valid2, busy2;
    logic [AW-1:0] mem_addr2;

    mem_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB), .MEM_LATENCY(LAT), .FAIR(0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req2), .i_addr(16'h0100), .i_grant(i_grant2), .i_fill_valid(i_fill_valid2), .i_done(i_done2),
        .d_req(d_req2), .d_addr(16'h0200), .d_grant(d_grant2), .d_fill_valid(d_fill_valid2), .d_done(d_done2),
        .d_wr_req(1'b0), .d_wr_addr(16'h0000), .d_wr_data(16'h0000), .d_wr_ack(d_wr_ack2),
        .fill_data(fill_data2), .fill_idx(fill_idx2),
        .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_data_valid(mem_data_valid2), .busy(busy2));

    // Memory: word = address unless written; reads return LAT cycles after issue
    logic [DW-1:0] wmem  [0:65535];
    logic          wflag [0:65535] = '{default: 1'b0};
    logic          pv  [LAT] = '{default: 1'b0};
    logic [AW-1:0] pa  [LAT] = '{default: '0};
    logic          pv2 [LAT] = '{default: 1'b0};
    logic [AW-1:0] pa2 [LAT] = '{default: '0};

    assign mem_data_valid  = pv[LAT-1] | force_v;
    assign mem_rdata       = wflag[pa[LAT-1]] ? wmem[pa[LAT-1]] : pa[LAT-1];
    assign mem_data_valid2 = pv2[LAT-1];
    assign mem_rdata2      = pa2[LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_wr) begin
            wmem[mem_addr]  <= mem_wdata;
            wflag[mem_addr] <= 1'b1;
        end
        pv[0]  <= mem_en && !mem_wr;
        pa[0]  <= mem_addr;
        pv2[0] <= mem_en2 && !mem_wr2;
        pa2[0] <= mem_addr2;
        for (int k = 1; k < LAT; k++) begin
            pv[k]  <= pv[k-1];
            pa[k]  <= pa[k-1];
            pv2[k] <= pv2[k-1];
            pa2[k] <= pa2[k-1];
        end
    end

    function automatic logic [DW-1:0] memrd(input logic [AW-1:0] a);
        return wflag[a] ? wmem[a] : a;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a timeline of transactions. kind 0 idle, 1 store, 2 I fill, 3 D fill;
    // t counts cycles since the transaction began.
    int            m_kind = 0;
    int            m_t = 0;
    logic          m_lastd = 1'b0;
    logic [AW-1:0] m_base = '0;
    logic          mdl_on = 1'b1;
    localparam logic [AW-1:0] MASK = ~AW'(2 * WPB - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind  <= 0;
            m_t     <= 0;
            m_lastd <= 1'b0;
            m_base  <= '0;
        end else if (m_kind == 0) begin
            m_t <= 0;
            if (d_wr_req) m_kind <= 1;
            else if (m_lastd && i_req) begin m_kind <= 2; m_base <= i_addr & MASK; end
            else if (d_req) begin m_kind <= 3; m_base <= d_addr & MASK; end
            else if (i_req) begin m_kind <= 2; m_base <= i_addr & MASK; end
        end else if (m_kind == 1 || m_t == WPB + LAT - 1) begin
            if (m_kind != 1) m_lastd <= (m_kind == 3);
            m_kind <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            logic fill, e_en, e_fv;
            #1;
            fill = (m_kind >= 2);
            e_en = (m_kind == 1) || (fill && m_t < WPB);
            e_fv = fill && m_t >= LAT;
            chk("busy", busy, m_kind != 0);
            chk("i_grant", i_grant, m_kind == 2);
            chk("d_grant", d_grant, m_kind == 3);
            chk("mem_en", mem_en, e_en);
            chk("mem_wr", mem_wr, m_kind == 1);
            chk("d_wr_ack", d_wr_ack, m_kind == 1);
            chk("i_fill_valid", i_fill_valid, e_fv && m_kind == 2);
            chk("d_fill_valid", d_fill_valid, e_fv && m_kind == 3);
            chk("i_done", i_done, m_kind == 2 && m_t == WPB + LAT - 1);
            chk("d_done", d_done, m_kind == 3 && m_t == WPB + LAT - 1);
            if (m_kind == 1) begin
                chk("wr_addr", mem_addr, d_wr_addr);
                chk("wr_data", mem_wdata, d_wr_data);
            end
            if (fill && m_t < WPB) chk("rd_addr", mem_addr, AW'(m_base + AW'(2 * m_t)));
            if (e_fv) begin
                chk("fill_idx", fill_idx, m_t - LAT);
                chk("fill_data", fill_data, memrd(AW'(m_base + AW'(2 * (m_t - LAT)))));
            end
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0: return i_done;
            1: return d_done;
            2: return d_wr_ack;
            3: return i_grant;
            4: return d_grant;
            default: return i_grant | d_grant;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int w, input int maxc);
        int n;
        n = 0;
        while (!sel(w) && n < maxc) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!sel(w)) begin
            errors++;
            $display("FAIL %s timeout after %0d cycles", nm, n);
        end
    endtask

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          en;
        logic [AW-1:0] maddr;
        logic          fv;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          done;
        logic          busy;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int c, n, fv_cnt, cnt, igr, dd;
        i_req = 0; d_req = 0; d_wr_req = 0;
        i_addr = 0; d_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        i_req2 = 0; d_req2 = 0; force_v = 0;

        // One 8-word I fill of block 0x1230 requested during cycle -1
        tbl[0] = '{req: 1'b1, addr: 16'h1236, en: 1'b0, maddr: 16'h0, fv: 1'b0, idx: 3'd0,
                   data: 16'h0, done: 1'b0, busy: 1'b0};
        for (int k = 1; k < 14; k++) begin
            c = k - 1;
            tbl[k].req   = (c <= 11);
            tbl[k].addr  = 16'h1236;
            tbl[k].en    = (c < 8);
            tbl[k].maddr = 16'h1230 + 16'(2 * c);
            tbl[k].fv    = (c >= 4 && c <= 11);
            tbl[k].idx   = 3'(c - 4);
            tbl[k].data  = 16'h1230 + 16'(2 * (c - 4));
            tbl[k].done  = (c == 11);
            tbl[k].busy  = (c <= 11);
        end

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grants", {i_grant, d_grant}, 0);
        chk("rst_mem", {mem_en, mem_wr, mem_addr, mem_wdata}, 0);
        chk("rst_fill", {i_fill_valid, d_fill_valid, i_done, d_done, d_wr_ack, fill_idx}, 0);
        chk("rst_fill_data", fill_data, mem_rdata);
        @(negedge clk); #2; rst_n = 1;
        repeat (2) @(negedge clk);

        // Vector table
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            i_req = tbl[k].req;
            i_addr = tbl[k].addr;
            #1;
            chk($sformatf("vec%0d_busy", k), busy, tbl[k].busy);
            chk($sformatf("vec%0d_grant", k), i_grant, tbl[k].busy);
            chk($sformatf("vec%0d_en", k), mem_en, tbl[k].en);
            if (tbl[k].en) chk($sformatf("vec%0d_addr", k), mem_addr, tbl[k].maddr);
            chk($sformatf("vec%0d_fv", k), i_fill_valid, tbl[k].fv);
            if (tbl[k].fv) begin
                chk($sformatf("vec%0d_idx", k), fill_idx, tbl[k].idx);
                chk($sformatf("vec%0d_data", k), fill_data, tbl[k].data);
            end
            chk($sformatf("vec%0d_done", k), i_done, tbl[k].done);
        end
        @(negedge clk); #1;

        // Simultaneous I and D with fairness
        d_addr = 16'h2004; i_addr = 16'h3008; d_req = 1; i_req = 1;
        wait_for("first_grant", 5, 5);
        chk("first_is_d", d_grant, 1);
        wait_for("d_done1", 1, 20);
        d_req = 0;
        @(negedge clk); #1;
        d_req = 1;
        wait_for("second_grant", 5, 5);
        chk("fair_i_next", i_grant, 1);
        wait_for("i_done1", 0, 20);
        i_req = 0;
        @(negedge clk); #1;
        wait_for("third_grant", 5, 5);
        chk("then_d", d_grant, 1);
        wait_for("d_done2", 1, 20);
        d_req = 0;
        @(negedge clk); #1;

        // Store and D fill together: the store goes first
        d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; d_addr = 16'h0040;
        d_wr_req = 1; d_req = 1;
        wait_for("wr_ack", 2, 5);
        chk("wr_mem_wr", mem_wr, 1);
        chk("wr_mem_addr", mem_addr, 16'h0040);
        chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
        chk("wr_no_grant", d_grant, 0);
        d_wr_req = 0;
        @(negedge clk); #1;
        chk("wr_then_idle", busy, 0);
        @(negedge clk); #1;
        chk("wr_then_fill_d", d_grant, 1);
        wait_for("d_done3", 1, 20);
        d_req = 0;
        @(negedge clk); #1;

        // Store raised during an I fill waits for done plus one idle cycle
        i_addr = 16'h4567; i_req = 1;
        wait_for("i_grant_w", 3, 5);
        repeat (3) begin @(negedge clk); #1; end
        d_wr_addr = 16'h5000; d_wr_data = 16'h1111; d_wr_req = 1;
        n = 0; cnt = 0;
        while (!i_done && n < 30) begin
            @(negedge clk); #1;
            n++;
            if (mem_wr) cnt++;
        end
        chk("wr_mid_fill_done", i_done, 1);
        chk("no_wr_during_fill", cnt, 0);
        i_req = 0;
        @(negedge clk); #1;
        chk("idle_before_wr", {busy, d_wr_ack}, 0);
        @(negedge clk); #1;
        chk("wr_after_idle", d_wr_ack, 1);
        d_wr_req = 0;
        @(negedge clk); #1;

        // Reset in cycle 6 of a fill
        i_addr = 16'h7000; i_req = 1;
        wait_for("i_grant_r", 3, 5);
        repeat (6) @(negedge clk);
        #2; rst_n = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_outs", {i_grant, d_grant, mem_en, mem_wr, mem_addr, i_fill_valid, i_done, fill_idx}, 0);
        i_req = 0;
        @(negedge clk); #2; rst_n = 1;
        fv_cnt = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (i_fill_valid || d_fill_valid) fv_cnt++;
        end
        chk("post_rst_no_fill_valid", fv_cnt, 0);
        i_addr = 16'h700A; i_req = 1;
        fv_cnt = 0; n = 0;
        while (!i_done && n < 30) begin
            @(negedge clk); #1;
            n++;
            if (i_fill_valid) fv_cnt++;
        end
        chk("post_rst_fill_done", i_done, 1);
        chk("post_rst_fill_words", fv_cnt, 8);
        i_req = 0;
        @(negedge clk); #1;

        // Stray valid in idle, then a fill whose request drops early
        force_v = 1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (i_fill_valid || d_fill_valid || i_done || d_done) cnt++;
        end
        chk("idle_valid_ignored", cnt, 0);
        force_v = 0;
        i_addr = 16'hFFF9; i_req = 1;
        wait_for("i_grant_drop", 3, 5);
        repeat (2) begin @(negedge clk); #1; end
        i_req = 0;
        fv_cnt = 0; n = 0;
        while (!i_done && n < 30) begin
            if (i_fill_valid) fv_cnt++;
            @(negedge clk); #1;
            n++;
        end
        if (i_fill_valid) fv_cnt++;
        chk("drop_req_done", i_done, 1);
        chk("drop_req_words", fv_cnt, 8);
        @(negedge clk); #1;

        // Random cache agents
        for (int cyc = 0; cyc < 1600; cyc++) begin
            logic go;
            @(negedge clk); #1;
            go = (cyc < 1500);
            if (i_req && i_done) i_req = 0;
            else if (!i_req && go && $urandom_range(0, 5) == 0) begin i_req = 1; i_addr = 16'($urandom); end
            if (d_req && d_done) d_req = 0;
            else if (!d_req && go && $urandom_range(0, 5) == 0) begin d_req = 1; d_addr = 16'($urandom); end
            if (d_wr_req && d_wr_ack) d_wr_req = 0;
            else if (!d_wr_req && go && $urandom_range(0, 9) == 0) begin
                d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
            end
        end
        chk("random_drained", {i_req, d_req, d_wr_req, busy}, 0);

        // Without fairness a held D request starves I
        i_req2 = 1; d_req2 = 1;
        igr = 0; dd = 0;
        repeat (60) begin
            @(negedge clk); #1;
            if (i_grant2) igr++;
            if (d_done2) dd++;
        end
        chk("nofair_i_starved", igr, 0);
        chk("nofair_d_fills", dd >= 3, 1);
        i_req2 = 0; d_req2 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
